// File: rtl/philv_pkg.sv
// Shared constants for the PhilosophyV execute/load-format unit:
// ALU function codes ({funct7[5], funct3}), the load opcode and the
// branch/load funct3 encodings.
package philv_pkg;

    localparam int ALU_FUNCT_WIDTH = 4;

    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SUB  = 4'b1000;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLL  = 4'b0001;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_SRA  = 4'b1101;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_OR   = 4'b0110;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/philv_exec_unit_if.sv
// Operand/result bundle between the decode-stage operand muxes (master)
// and the execute unit (slave). The misalign signal exists only when
// PHILV_MISALIGN_EN is defined.
interface philv_exec_if #(
    parameter int N = 32
);
    import philv_pkg::*;

    logic [ALU_FUNCT_WIDTH-1:0] funct;
    logic [N-1:0]               x;
    logic [N-1:0]               y;
    logic [6:0]                 opcode;
    logic [2:0]                 funct3;
    logic [N-1:0]               mem_rd_data;
    logic [1:0]                 byte_off;

    logic [N-1:0]               z;
    logic                       equal;
    logic                       branch;
    logic [N-1:0]               ld_data;
    logic [N-1:0]               z_q;
    logic                       branch_q;
    logic [N-1:0]               ld_data_q;
`ifdef PHILV_MISALIGN_EN
    logic                       misalign;

    modport master (
        output funct, x, y, opcode, funct3, mem_rd_data, byte_off,
        input  z, equal, branch, ld_data, z_q, branch_q, ld_data_q, misalign
    );

    modport slave (
        input  funct, x, y, opcode, funct3, mem_rd_data, byte_off,
        output z, equal, branch, ld_data, z_q, branch_q, ld_data_q, misalign
    );
`else
    modport master (
        output funct, x, y, opcode, funct3, mem_rd_data, byte_off,
        input  z, equal, branch, ld_data, z_q, branch_q, ld_data_q
    );

    modport slave (
        input  funct, x, y, opcode, funct3, mem_rd_data, byte_off,
        output z, equal, branch, ld_data, z_q, branch_q, ld_data_q
    );
`endif

endinterface

// File: rtl/philv_alu.sv
// 32-bit combinational ALU plus operand equality compare.
// Unknown function codes yield zero so a stray decode never leaks data.
module philv_alu
    import philv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               y,
    output logic [N-1:0]               z,
    output logic                       equal
);

    logic [4:0] shamt;

    assign shamt = y[4:0];

    // Function select; SLT/SLTU produce a zero-extended single bit.
    always_comb begin
        z = '0;
        case (funct)
            ALU_ADD:  z = x + y;
            ALU_SUB:  z = x - y;
            ALU_SLL:  z = x << shamt;
            ALU_SLT:  z = {{(N-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_SLTU: z = {{(N-1){1'b0}}, (x < y)};
            ALU_XOR:  z = x ^ y;
            ALU_SRL:  z = x >> shamt;
            ALU_SRA:  z = $unsigned($signed(x) >>> shamt);
            ALU_OR:   z = x | y;
            ALU_AND:  z = x & y;
            default:  z = '0;
        endcase
    end

    // Equality is independent of funct so BEQ/BNE need no ALU setup.
    always_comb begin
        equal = (x == y);
    end

endmodule

// File: rtl/philv_exec_unit.sv
// PhilosophyV execute/load-format unit: ALU, branch decision and load data
// formatter, with registered copies of the results for the next FSM state.
// Optional feature macro: PHILV_MISALIGN_EN adds the misaligned-load flag.
module philv_exec_unit
    import philv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    philv_exec_if.slave  bus
);

    logic [N-1:0] alu_z;
    logic         alu_equal;
    logic         branch_c;
    logic [N-1:0] ld_data_c;
    logic [7:0]   ld_byte;
    logic [15:0]  ld_half;

    philv_alu #(.N(N)) u_alu (
        .funct (bus.funct),
        .x     (bus.x),
        .y     (bus.y),
        .z     (alu_z),
        .equal (alu_equal)
    );

    assign bus.z     = alu_z;
    assign bus.equal = alu_equal;

    // Branch decision; the controller has already steered SUB/SLT/SLTU into z.
    always_comb begin
        branch_c = 1'b0;
        case (bus.funct3)
            F3_BEQ:           branch_c = alu_equal;
            F3_BNE:           branch_c = !alu_equal;
            F3_BLT, F3_BLTU:  branch_c = alu_z[0];
            F3_BGE, F3_BGEU:  branch_c = !alu_z[0];
            default:          branch_c = 1'b0;
        endcase
    end

    // Little-endian byte/halfword lanes; halfword select uses byte_off[1] only.
    always_comb begin
        ld_byte = 8'h00;
        case (bus.byte_off)
            2'd0: ld_byte = bus.mem_rd_data[7:0];
            2'd1: ld_byte = bus.mem_rd_data[15:8];
            2'd2: ld_byte = bus.mem_rd_data[23:16];
            2'd3: ld_byte = bus.mem_rd_data[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = bus.byte_off[1] ? bus.mem_rd_data[31:16] : bus.mem_rd_data[15:0];
    end

    // Load formatting; non-load opcodes pass the memory word straight through.
    always_comb begin
        ld_data_c = bus.mem_rd_data;
        if (bus.opcode == OP_LOAD) begin
            case (bus.funct3)
                F3_LB:   ld_data_c = {{(N-8){ld_byte[7]}}, ld_byte};
                F3_LBU:  ld_data_c = {{(N-8){1'b0}}, ld_byte};
                F3_LH:   ld_data_c = {{(N-16){ld_half[15]}}, ld_half};
                F3_LHU:  ld_data_c = {{(N-16){1'b0}}, ld_half};
                default: ld_data_c = bus.mem_rd_data;
            endcase
        end
    end

    assign bus.branch  = branch_c;
    assign bus.ld_data = ld_data_c;

    // Result registers for the next controller state; cleared by sync reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.z_q       <= '0;
            bus.branch_q  <= 1'b0;
            bus.ld_data_q <= '0;
        end else begin
            bus.z_q       <= alu_z;
            bus.branch_q  <= branch_c;
            bus.ld_data_q <= ld_data_c;
        end
    end

`ifdef PHILV_MISALIGN_EN
    logic misalign_c;
    logic misalign_q;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; data still formats.
    always_comb begin
        misalign_c = 1'b0;
        if (bus.opcode == OP_LOAD) begin
            case (bus.funct3)
                F3_LH, F3_LHU: misalign_c = bus.byte_off[0];
                F3_LW:         misalign_c = (bus.byte_off != 2'd0);
                default:       misalign_c = 1'b0;
            endcase
        end
    end

    assign bus.misalign = misalign_c;

    // Registered misalign flag held for the controller's trap decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_c;
        end
    end
`endif

endmodule

// File: tb/tb_philv_exec_unit.sv
// Directed self-checking bench for philv_exec_unit.
module tb_philv_exec_unit;
    import philv_pkg::*;

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } ld_vec_t;

    localparam alu_vec_t ALU_V [12] = '{
        '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_SUB,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE},
        '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000},
        '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000},
        '{ALU_SLL,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE},
        '{ALU_XOR,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE},
        '{ALU_OR,   32'h0000F000, 32'h00000001, 32'h0000F001},
        '{ALU_AND,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{4'b1001,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002}
    };

    localparam ld_vec_t LD_V [10] = '{
        '{F3_LB,  2'd2, 32'hFFFFFFFF},
        '{F3_LB,  2'd1, 32'h0000007F},
        '{F3_LBU, 2'd3, 32'h00000080},
        '{F3_LB,  2'd3, 32'hFFFFFF80},
        '{F3_LH,  2'd2, 32'hFFFF80FF},
        '{F3_LH,  2'd3, 32'hFFFF80FF},
        '{F3_LHU, 2'd0, 32'h00007F01},
        '{F3_LHU, 2'd2, 32'h000080FF},
        '{F3_LW,  2'd0, 32'h80FF7F01},
        '{3'b011, 2'd1, 32'h80FF7F01}
    };

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    philv_exec_if #(.N(32)) bus ();

    philv_exec_unit #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.funct = ALU_ADD; bus.x = 32'd3; bus.y = 32'd4;
        bus.opcode = OP_LOAD; bus.funct3 = F3_BNE;
        bus.mem_rd_data = 32'hDEADBEEF; bus.byte_off = 2'd0;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.z_q !== 32'h0) begin
            failures++; $display("FAIL reset_z_q got=%h exp=%h", bus.z_q, 32'h0);
        end
        checks++;
        if (bus.branch_q !== 1'b0) begin
            failures++; $display("FAIL reset_branch_q got=%b exp=0", bus.branch_q);
        end
        checks++;
        if (bus.ld_data_q !== 32'h0) begin
            failures++; $display("FAIL reset_ld_data_q got=%h exp=%h", bus.ld_data_q, 32'h0);
        end
        checks++;
        if (bus.z !== 32'd7) begin
            failures++; $display("FAIL reset_comb_z got=%h exp=%h", bus.z, 32'd7);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        bus.opcode = 7'b0110011; bus.funct3 = 3'b010;
        for (int i = 0; i < 12; i++) begin
            bus.funct = ALU_V[i].f; bus.x = ALU_V[i].x; bus.y = ALU_V[i].y;
            #1;
            checks++;
            if (bus.z !== ALU_V[i].exp) begin
                failures++;
                $display("FAIL alu_vec%0d funct=%b got=%h exp=%h", i, ALU_V[i].f, bus.z, ALU_V[i].exp);
            end
        end
        bus.funct = ALU_AND; bus.x = 32'h1234; bus.y = 32'h1234;
        #1;
        checks++;
        if (bus.equal !== 1'b1) begin
            failures++; $display("FAIL equal_same got=%b exp=1", bus.equal);
        end
        bus.y = 32'h1235;
        #1;
        checks++;
        if (bus.equal !== 1'b0) begin
            failures++; $display("FAIL equal_diff got=%b exp=0", bus.equal);
        end
    endtask

    task automatic test_branch();
        bus.opcode = 7'b1100011;
        bus.funct = ALU_SUB; bus.x = 32'd5; bus.y = 32'd5; bus.funct3 = F3_BEQ;
        #1;
        checks++;
        if (bus.branch !== 1'b1) begin
            failures++; $display("FAIL beq_taken got=%b exp=1", bus.branch);
        end
        bus.funct3 = F3_BNE;
        #1;
        checks++;
        if (bus.branch !== 1'b0) begin
            failures++; $display("FAIL bne_not_taken got=%b exp=0", bus.branch);
        end
        bus.funct = ALU_SLT; bus.x = 32'hFFFFFFFE; bus.y = 32'd3; bus.funct3 = F3_BLT;
        #1;
        checks++;
        if (bus.branch !== 1'b1) begin
            failures++; $display("FAIL blt_taken got=%b exp=1", bus.branch);
        end
        bus.funct3 = F3_BGE;
        #1;
        checks++;
        if (bus.branch !== 1'b0) begin
            failures++; $display("FAIL bge_not_taken got=%b exp=0", bus.branch);
        end
        bus.funct3 = 3'b010;
        #1;
        checks++;
        if (bus.branch !== 1'b0) begin
            failures++; $display("FAIL f3_010_never got=%b exp=0", bus.branch);
        end
        bus.funct = ALU_SLTU; bus.funct3 = F3_BLTU;
        #1;
        checks++;
        if (bus.branch !== 1'b0) begin
            failures++; $display("FAIL bltu_not_taken got=%b exp=0", bus.branch);
        end
        bus.funct3 = F3_BGEU;
        #1;
        checks++;
        if (bus.branch !== 1'b1) begin
            failures++; $display("FAIL bgeu_taken got=%b exp=1", bus.branch);
        end
    endtask

    task automatic test_load();
        bus.opcode = OP_LOAD; bus.mem_rd_data = 32'h80FF7F01;
        for (int i = 0; i < 10; i++) begin
            bus.funct3 = LD_V[i].f3; bus.byte_off = LD_V[i].off;
            #1;
            checks++;
            if (bus.ld_data !== LD_V[i].exp) begin
                failures++;
                $display("FAIL load_vec%0d f3=%b off=%0d got=%h exp=%h",
                         i, LD_V[i].f3, LD_V[i].off, bus.ld_data, LD_V[i].exp);
            end
        end
        bus.opcode = 7'b0110011; bus.mem_rd_data = 32'h12345678;
        bus.funct3 = 3'b000; bus.byte_off = 2'd3;
        #1;
        checks++;
        if (bus.ld_data !== 32'h12345678) begin
            failures++; $display("FAIL non_load_pass got=%h exp=%h", bus.ld_data, 32'h12345678);
        end
    endtask

    task automatic test_registered();
        bus.funct = ALU_ADD; bus.x = 32'd3; bus.y = 32'd4;
        bus.opcode = OP_LOAD; bus.funct3 = F3_BNE;
        bus.mem_rd_data = 32'h80FF7F01; bus.byte_off = 2'd2;
        tick();
        checks++;
        if (bus.z_q !== 32'd7) begin
            failures++; $display("FAIL reg_z_q got=%h exp=%h", bus.z_q, 32'd7);
        end
        checks++;
        if (bus.branch_q !== 1'b1) begin
            failures++; $display("FAIL reg_branch_q got=%b exp=1", bus.branch_q);
        end
        checks++;
        if (bus.ld_data_q !== 32'hFFFF80FF) begin
            failures++; $display("FAIL reg_ld_data_q got=%h exp=%h", bus.ld_data_q, 32'hFFFF80FF);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.z_q !== 32'h0 || bus.branch_q !== 1'b0 || bus.ld_data_q !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid_op got z_q=%h br_q=%b ld_q=%h exp all zero",
                     bus.z_q, bus.branch_q, bus.ld_data_q);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.z_q !== 32'd7) begin
            failures++; $display("FAIL resume_z_q got=%h exp=%h", bus.z_q, 32'd7);
        end
        bus.x = 32'd10; bus.y = 32'd20;
        tick();
        checks++;
        if (bus.z_q !== 32'd30) begin
            failures++; $display("FAIL back_to_back_z_q got=%h exp=%h", bus.z_q, 32'd30);
        end
    endtask

`ifdef PHILV_MISALIGN_EN
    task automatic test_misalign();
        bus.opcode = OP_LOAD; bus.mem_rd_data = 32'h80FF7F01;
        bus.funct3 = F3_LW; bus.byte_off = 2'd1;
        #1;
        checks++;
        if (bus.misalign !== 1'b1) begin
            failures++; $display("FAIL mis_lw_off1 got=%b exp=1", bus.misalign);
        end
        bus.funct3 = F3_LH; bus.byte_off = 2'd2;
        #1;
        checks++;
        if (bus.misalign !== 1'b0) begin
            failures++; $display("FAIL mis_lh_off2 got=%b exp=0", bus.misalign);
        end
        bus.byte_off = 2'd3;
        #1;
        checks++;
        if (bus.misalign !== 1'b1) begin
            failures++; $display("FAIL mis_lh_off3 got=%b exp=1", bus.misalign);
        end
        bus.funct3 = F3_LB;
        #1;
        checks++;
        if (bus.misalign !== 1'b0) begin
            failures++; $display("FAIL mis_lb_off3 got=%b exp=0", bus.misalign);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_registered();
`ifdef PHILV_MISALIGN_EN
        test_misalign();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/philv_exec_unit.md
# philv_exec_unit

Execute/load-format unit of the PhilosophyV RV32I multicycle core: a 32-bit ALU, a branch-decision block driven by the ALU result, and a load-data formatter that extracts and extends bytes or halfwords from a data-memory word. It sits between the decode-stage operand muxes and the EX/MEM state registers. All datapath outputs are combinational; registered copies are provided for the next FSM state.

## Interface
- N, default 32: datapath width (only 32 supported).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- funct  in  4  ALU function, encoded as {funct7[5], funct3}.
- x  in  N  operand A.
- y  in  N  operand B.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- mem_rd_data  in  N  aligned word read from data memory.
- byte_off  in  2  low address bits of the load address.
- z  out  N  ALU result (combinational).
- equal  out  1  x == y (combinational).
- branch  out  1  branch taken (combinational).
- ld_data  out  N  formatted load data (combinational).
- z_q  out  N  registered z.
- branch_q  out  1  registered branch.
- ld_data_q  out  N  registered ld_data.
- misalign  out  1  misaligned load flag; present only with PHILV_MISALIGN_EN.

## Operation
- ALU, combinational:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - All other codes produce z = 0.
  - Shift amount is y[4:0]. Add and subtract wrap modulo 2^32. SLT and SLTU return 0 or 1 zero-extended.
- equal is computed as x == y regardless of funct.
- Branch, combinational; the controller is responsible for selecting SUB/SLT/SLTU on the ALU as needed:
  - funct3 000 BEQ: equal.
  - 001 BNE: !equal.
  - 100 BLT and 110 BLTU: z[0].
  - 101 BGE and 111 BGEU: !z[0].
  - 010 and 011: 0.
- Load formatter, active only when opcode == 7'b0000011. For any other opcode, ld_data = mem_rd_data unchanged.
  - LB 000: byte at byte_off, sign-extended.
  - LBU 100: byte at byte_off, zero-extended.
  - LH 001: halfword at byte_off[1], sign-extended.
  - LHU 101: halfword at byte_off[1], zero-extended.
  - LW 010: full word.
  - Other funct3 values: full word.
- Byte order is little-endian. byte_off = 0 selects bits [7:0]; byte_off = 3 selects bits [31:24].
- Halfword loads ignore byte_off[0].

## Timing
- Combinational path from inputs to z, equal, branch and ld_data: zero latency.
- z_q, branch_q and ld_data_q update on every rising clk edge with no enable, so the latency is 1 cycle.
- When rst = 1 at a clock edge, z_q, branch_q and ld_data_q all become 0 (and misalign_q if present). Combinational outputs are unaffected by rst.
- If rst is asserted during an operation, the next-cycle registered values are 0. Operation resumes normally on the first edge after rst deasserts.
- No handshake is required: outputs are valid whenever the inputs are stable.

## Configuration
- PHILV_MISALIGN_EN defined: adds the misalign output.
  - misalign = 1 for LH/LHU with byte_off[0] = 1, or for LW with byte_off != 0.
  - misalign = 0 for all other cases.
  - A registered copy, misalign_q, is kept internally and reset to 0.
  - Data is still formatted as specified above.
- PHILV_MISALIGN_EN undefined: the misalign port does not exist and no checking logic is generated.

## Structure
- Shared package philv_pkg holds:
  - ALU function localparams (ALU_ADD, ALU_SUB, and so on), with ALU_FUNCT_WIDTH = 4.
  - Opcode constant OP_LOAD.
  - funct3 constants for branches (F3_BEQ and so on) and loads (F3_LB and so on).
- One natural sub-module: philv_alu, covering the ALU and equal. The branch and load logic live in the top module.

## Test plan
- ALU: x = 0xFFFFFFFF, y = 1.
  - ADD -> z = 0. SUB -> z = 0xFFFFFFFE.
  - SLT -> z = 1. SLTU -> z = 0.
  - SRA with x = 0x80000000, y = 4 -> z = 0xF8000000. SRL with the same operands -> z = 0x08000000.
- Branch:
  - x = y = 5, funct3 = 000 -> branch = 1. funct3 = 001 -> branch = 0.
  - SLT with x = -2, y = 3, funct3 = 100 -> branch = 1. funct3 = 101 -> branch = 0.
- Loads with mem_rd_data = 0x80FF7F01:
  - LB, byte_off = 2 -> ld_data = 0xFFFFFFFF.
  - LBU, byte_off = 3 -> 0x00000080.
  - LH, byte_off = 2 -> 0xFFFF80FF.
  - LHU, byte_off = 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Non-load opcode 0110011 with mem_rd_data = 0x12345678 and funct3 = 000 -> ld_data = 0x12345678.
- Registered outputs:
  - Drive ADD with x = 3, y = 4 and clock once -> z_q = 7.
  - Assert rst for one edge -> z_q = 0, branch_q = 0, ld_data_q = 0.
  - Deassert rst and clock once -> z_q = 7.
- With PHILV_MISALIGN_EN defined:
  - LW, byte_off = 1 -> misalign = 1.
  - LH, byte_off = 2 -> misalign = 0.
  - LH, byte_off = 3 -> misalign = 1.
